mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (IR load path) and the data requester (load/store path).
- Serialises requests and drives a req/ack memory bus with variable latency.
- Returns a registered one-cycle ack plus read data to the winning requester.
- Sits between the multicycle control unit's memRead/memWrite-driven datapath and the memory; `bus_error` feeds the control unit's error/halt input.

Parameters:
- AW, 32, address width
- DW, 32, data width; byte enables are DW/8 wide
- TIMEOUT_CYCLES, 255, max BUSY cycles before a bus error (used only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  AW  fetch address
- if_ack  out  1  one-cycle pulse: fetch done, if_rdata valid
- if_rdata  out  DW  fetched word, held until next fetch completes
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_be  in  DW/8  store byte enables
- d_ack  out  1  one-cycle pulse: data access done
- d_rdata  out  DW  load data, held until next load completes
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  AW  bus address
- mem_wdata  out  DW  bus write data
- mem_be  out  DW/8  bus byte enables; all ones for fetch and loads
- mem_ack  in  1  bus completion, single-cycle
- mem_rdata  in  DW  valid when mem_ack=1
- bus_error  out  1  sticky timeout error

Behaviour:
- Reset (rst_n=0 at a clk edge) applies regardless of state, including mid-transaction:
  - state=IDLE, last_grant=DATA
  - all outputs 0; if_rdata=d_rdata=0
  - an in-flight mem_req is dropped; a late mem_ack after reset is ignored
- States: IDLE, BUSY, RESP, ERR.
- IDLE:
  - Sample if_req and d_req.
  - Only one asserted: grant it.
  - Both asserted: round-robin; the requester not in last_grant wins.
  - On grant, latch addr/we/wdata/be into bus registers and owner=IF or D; update last_grant; go to BUSY.
  - mem_req is registered: it rises the cycle after the grant decision.
- BUSY:
  - mem_req=1; bus outputs stable.
  - On mem_ack=1: capture mem_rdata into the owner's rdata register (loads and fetches only; stores leave d_rdata unchanged).
  - Then mem_req=0 next cycle; go to RESP.
- RESP:
  - Owner's ack=1 for exactly this cycle; go to IDLE.
  - Requests sampled in RESP are ignored. A requester must drop req the cycle after its ack or it is regranted.
- Latency with zero-wait memory:
  - req seen at cycle N, mem_req at N+1, mem_ack at N+1, ack at N+2, IDLE at N+3.
  - Each wait cycle on mem_ack adds one cycle.
- Bus outputs other than mem_req keep their last values when idle. mem_we and mem_be hold valid values only while mem_req=1.
- mem_ack outside BUSY is ignored.
- The losing requester stays pending with no ack and is granted in its next IDLE.
- ERR: reachable only with the timeout feature.
  - mem_req=0, bus_error=1, no acks.
  - Left only via reset.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter, sized $clog2(TIMEOUT_CYCLES+1), clears on BUSY entry and increments each BUSY cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES, go to ERR next cycle.
  - bus_error rises with ERR and stays high until reset.
- Undefined:
  - No counter; BUSY waits indefinitely.
  - bus_error tied to 0.

Decomposition:
- Package mem_arb_pkg:
  - state typedef (IDLE, BUSY, RESP, ERR)
  - owner typedef (OWN_IF, OWN_D)
  - constants for default AW/DW
- Optional sub-module rr_arb2: 2-input round-robin pick from two reqs plus last_grant, outputting grant_d. Purely combinational, instantiated once.
- Everything else is flat in mem_port_arbiter.

Test Plan:
- Reset, single fetch:
  - Stimulus: rst_n low 2 cycles; if_req=1, if_addr=0x100; memory returns 0x00000013 with 0 wait.
  - Required: mem_req at N+1 with mem_addr=0x100 and mem_we=0; if_ack pulse at N+2 with if_rdata=0x00000013; d_ack never asserts.
- Store with byte enables and 3 wait states:
  - Stimulus: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_be=4'b0011.
  - Required: mem_req high exactly 4 cycles with stable bus outputs; d_ack pulse once; d_rdata unchanged.
- Simultaneous requests after reset:
  - Stimulus: if_req and d_req both asserted.
  - Required: fetch granted first (last_grant=DATA), data granted in the next IDLE; a second tie goes to fetch again only after the data grant.
- Reset mid-transaction:
  - Stimulus: rst_n=0 while in BUSY, then mem_ack=1 the following cycle.
  - Required: mem_req=0 after the reset edge; no ack pulse; state IDLE; rdata registers=0.
- Timeout with MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4:
  - Stimulus: load request that never receives mem_ack.
  - Required: bus_error=1 after 4 BUSY cycles and mem_req=0; later d_req is ignored until reset.
- Timeout without the macro:
  - Stimulus: same load request with no mem_ack.
  - Required: stalls 1000 cycles with bus_error=0; late mem_ack completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DefAw = 32;
  localparam int unsigned DefDw = 32;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp,
    StErr
  } state_e;

  typedef enum logic {
    OwnIf,
    OwnD
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between fetch and data requesters.
module rr_arb2 (
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic last_grant_d_i,
  output logic grant_valid_o,
  output logic grant_d_o
);

  always_comb begin
    grant_valid_o = if_req_i | d_req_i;
    // On a tie, the requester that did not win last time goes first.
    if (if_req_i && d_req_i) begin
      grant_d_o = ~last_grant_d_i;
    end else begin
      grant_d_o = d_req_i;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory port between instruction fetch and data access.
// Optional bus timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW             = DefAw,
  parameter int unsigned DW             = DefDw,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ack,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            bus_error
);

  localparam int unsigned BW = DW / 8;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  owner_e          last_q, last_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]   mem_be_q, mem_be_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            if_ack_q, if_ack_d;
  logic            d_ack_q, d_ack_d;
  logic            grant_valid;
  logic            grant_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  rr_arb2 u_rr_arb2 (
    .if_req_i       (if_req),
    .d_req_i        (d_req),
    .last_grant_d_i (last_q == OwnD),
    .grant_valid_o  (grant_valid),
    .grant_d_o      (grant_d)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d   = StBusy;
          mem_req_d = 1'b1;
          owner_d   = grant_d ? OwnD : OwnIf;
          last_d    = owner_d;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
          if (grant_d) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_we ? d_be : '1;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
            mem_be_d   = '1;
          end
        end
      end
      StBusy: begin
        if (mem_ack) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          if (owner_q == OwnIf) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            // Stores complete without touching the load data register.
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          state_d   = StErr;
          mem_req_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StResp: state_d = StIdle;
      StErr:  state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= OwnIf;
      last_q      <= OwnD;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus_error = (state_q == StErr);
`else
  assign bus_error = 1'b0;
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  localparam int PolRand   = 0;
  localparam int PolFixed  = 1;
  localparam int PolNever  = 2;
  localparam int PolAlways = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_error;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW             (32),
    .DW             (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .bus_error (bus_error)
  );

  int checks = 0;
  int failures = 0;

  // Transaction-level model: bus outstanding flag, who acks this cycle, and register images.
  bit          m_busy;
  int          m_ack;      // 0 none, 1 fetch, 2 data
  bit          m_last_d;
  bit          m_own_d;
  bit          m_err;
  int unsigned m_bcnt;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_d_rd;
  logic        m_we;
  logic [3:0]  m_be;

  int          pol = PolFixed;
  int unsigned wait_n = 0;
  bit          fix_rd = 1'b1;
  bit          seen_if_ack, seen_d_ack;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_ack = 0; m_last_d = 1'b1; m_own_d = 1'b0; m_err = 1'b0; m_bcnt = 0;
    m_addr = '0; m_wdata = '0; m_if_rd = '0; m_d_rd = '0; m_we = 1'b0; m_be = '0;
  endtask

  task automatic compare();
    check1("mem_req", mem_req, m_busy);
    check1("if_ack", if_ack, m_ack == 1);
    check1("d_ack", d_ack, m_ack == 2);
    check32("if_rdata", if_rdata, m_if_rd);
    check32("d_rdata", d_rdata, m_d_rd);
    check1("bus_error", bus_error, m_err);
    check32("mem_addr", mem_addr, m_addr);
    if (m_busy) begin
      check1("mem_we", mem_we, m_we);
      check32("mem_be", {28'd0, mem_be}, {28'd0, m_be});
      if (m_we) check32("mem_wdata", mem_wdata, m_wdata);
    end
    seen_if_ack = (m_ack == 1);
    seen_d_ack  = (m_ack == 2);
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_advance();
    int prev_ack;
    bit pick_d;
    prev_ack = m_ack;
    m_ack = 0;
    if (!rst_n) begin
      model_reset();
    end else if (m_err) begin
      m_err = 1'b1;
    end else if (m_busy) begin
      if (mem_ack) begin
        m_busy = 1'b0;
        m_ack = m_own_d ? 2 : 1;
        if (!m_own_d) m_if_rd = mem_rdata;
        else if (!m_we) m_d_rd = mem_rdata;
      end else begin
        m_bcnt++;
`ifdef MEM_ARB_TIMEOUT_EN
        if (m_bcnt == TO) begin
          m_busy = 1'b0;
          m_err = 1'b1;
        end
`endif
      end
    end else if (prev_ack == 0 && (if_req || d_req)) begin
      pick_d = (if_req && d_req) ? !m_last_d : d_req;
      m_own_d = pick_d;
      m_last_d = pick_d;
      m_busy = 1'b1;
      m_bcnt = 0;
      if (pick_d) begin
        m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_be = d_we ? d_be : 4'hf;
      end else begin
        m_addr = if_addr; m_we = 1'b0; m_be = 4'hf;
      end
    end
  endtask

  task automatic gen_mem();
    case (pol)
      PolRand:  mem_ack = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      PolFixed: mem_ack = m_busy && (m_bcnt >= wait_n);
      PolNever: mem_ack = 1'b0;
      default:  mem_ack = 1'b1;
    endcase
    if (!fix_rd) mem_rdata = $urandom;
  endtask

  task automatic gen_reqs();
    if (seen_if_ack) if_req = 1'b0;
    else if (!if_req && $urandom_range(0, 2) == 0) begin
      if_req = 1'b1;
      if_addr = $urandom;
    end
    if (seen_d_ack) d_req = 1'b0;
    else if (!d_req && $urandom_range(0, 2) == 0) begin
      d_req = 1'b1;
      d_we = 1'($urandom_range(0, 1));
      d_addr = $urandom;
      d_wdata = $urandom;
      d_be = 4'($urandom);
    end
    rst_n = ($urandom_range(0, 399) != 0);
  endtask

  // Inputs are set just after a rising edge; outputs are compared on the falling edge.
  task automatic cyc();
    gen_mem();
    @(negedge clk);
    compare();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq, nack, if_ph, d_ph;
    bit prev_req, got;
    logic [31:0] grants[$];
    logic [31:0] exp_g[4];
    logic [31:0] g;

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check1("reset_mem_req", mem_req, 1'b0);
    check32("reset_if_rdata", if_rdata, 32'h0);
    check32("reset_d_rdata", d_rdata, 32'h0);
    check1("reset_bus_error", bus_error, 1'b0);

    // Single zero-wait fetch.
    rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'h0000_0013;
    pol = PolFixed; wait_n = 0;
    cyc();
    check1("fetch_mem_req_n1", mem_req, 1'b1);
    check32("fetch_mem_addr_n1", mem_addr, 32'h100);
    check1("fetch_mem_we_n1", mem_we, 1'b0);
    cyc();
    check1("fetch_if_ack_n2", if_ack, 1'b1);
    check32("fetch_if_rdata_n2", if_rdata, 32'h0000_0013);
    check1("fetch_d_ack_n2", d_ack, 1'b0);
    if_req = 1'b0;
    cyc();
    check1("fetch_if_ack_n3", if_ack, 1'b0);
    cyc();

    // Store with byte enables and three wait states.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    wait_n = 3; nreq = 0; nack = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (mem_req) begin
        nreq++;
        check32("store_be", {28'd0, mem_be}, 32'h3);
        check32("store_wdata", mem_wdata, 32'hDEAD_BEEF);
      end
      if (d_ack) begin
        nack++;
        d_req = 1'b0;
      end
    end
    check32("store_req_cycles", nreq, 32'd4);
    check32("store_ack_count", nack, 32'd1);
    check32("store_d_rdata", d_rdata, 32'h0);

    // Ties alternate: expected grant order 0x300 (fetch), 0x400, 0x500, 0x600.
    do_reset();
    if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    mem_rdata = 32'h55; wait_n = 1; if_ph = 0; d_ph = 0; prev_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (mem_req && !prev_req) grants.push_back(mem_addr);
      prev_req = mem_req;
      if (if_ack) begin
        if_req = 1'b0; if_ph++;
      end else if (!if_req && if_ph == 1) begin
        if_req = 1'b1; if_addr = 32'h500;
      end
      if (d_ack) begin
        d_req = 1'b0; d_ph++;
      end else if (!d_req && d_ph == 1) begin
        d_req = 1'b1; d_addr = 32'h600;
      end
    end
    exp_g = '{32'h300, 32'h400, 32'h500, 32'h600};
    check32("tie_grant_count", grants.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      g = (k < grants.size()) ? grants[k] : 32'hFFFF_FFFF;
      check32("tie_grant_order", g, exp_g[k]);
    end

    // Reset while BUSY, then a stray mem_ack.
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800; mem_rdata = 32'h1234_5678;
    pol = PolNever;
    cyc();
    check1("midrst_busy", mem_req, 1'b1);
    rst_n = 1'b0;
    cyc();
    check1("midrst_req_dropped", mem_req, 1'b0);
    rst_n = 1'b1; d_req = 1'b0; pol = PolAlways;
    cyc();
    check1("midrst_no_d_ack", d_ack, 1'b0);
    check1("midrst_no_if_ack", if_ack, 1'b0);
    check32("midrst_d_rdata", d_rdata, 32'h0);
    check32("midrst_if_rdata", if_rdata, 32'h0);
    check1("midrst_idle", mem_req, 1'b0);

    // Load that never sees mem_ack.
    pol = PolNever; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h900; mem_rdata = 32'hCAFE_F00D;
`ifdef MEM_ARB_TIMEOUT_EN
    nreq = 0; nack = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (mem_req) nreq++;
    end
    check32("to_busy_cycles", nreq, 32'd4);
    check1("to_bus_error", bus_error, 1'b1);
    check1("to_mem_req", mem_req, 1'b0);
    pol = PolAlways;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (d_ack || mem_req) nack++;
    end
    check32("to_ignored", nack, 32'd0);
    d_req = 1'b0;
    pol = PolFixed;
    do_reset();
    check1("to_cleared", bus_error, 1'b0);
`else
    repeat (1000) cyc();
    check1("stall_bus_error", bus_error, 1'b0);
    check1("stall_mem_req", mem_req, 1'b1);
    pol = PolAlways; got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      cyc();
      got = d_ack;
    end
    check1("stall_late_ack", got, 1'b1);
    check32("stall_d_rdata", d_rdata, 32'hCAFE_F00D);
    d_req = 1'b0;
    pol = PolFixed;
    cyc();
`endif

    // Randomised traffic with random wait states, stray acks and occasional resets.
    if_req = 1'b0; d_req = 1'b0;
    do_reset();
    pol = PolRand; fix_rd = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      gen_reqs();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
